// File: rtl/seq_add64_pkg.sv
// Shared types and constants for the sequential 64-bit add/subtract unit.
// Slice geometry, FSM state encoding and flag bit positions.
package add64_pkg;

    localparam int SLICE_W  = 16;
    localparam int N_SLICES = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_add64_cla.sv
// 16-bit carry-lookahead adder built from four 4-bit groups.
// Group generate/propagate terms resolve the inter-group carries.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic [15:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate and propagate for each 4-bit group.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[k*4 +: 4];
            gg[k] = g[k*4+3]
                  | (p[k*4+3] & g[k*4+2])
                  | (p[k*4+3] & p[k*4+2] & g[k*4+1])
                  | (p[k*4+3] & p[k*4+2] & p[k*4+1] & g[k*4]);
        end
    end

    // Lookahead carries into each group, plus the final carry out.
    always_comb begin
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0])
              | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1])
              | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2])
              | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    end

    // Bit carries inside each group start from the group carry-in.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                c[i] = gc[i/4];
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/seq_add64.sv
// Multi-cycle 64-bit add/subtract: one 16-bit CLA reused for four passes.
// Define SEQ_ADD64_FLAGS_EN to produce registered NZCV flags.
module seq_add64
    import add64_pkg::*;
#(
    parameter int WIDTH = SLICE_W * N_SLICES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    localparam int HI = WIDTH - SLICE_W;

    state_t             state;
    logic [1:0]         idx;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result;
    logic [SLICE_W-1:0] s_a;
    logic [SLICE_W-1:0] s_b;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;
    logic               last;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = result;
    assign last       = (idx == 2'(N_SLICES - 1));

    assign s_a = a_q[idx*SLICE_W +: SLICE_W];
    assign s_b = b_q[idx*SLICE_W +: SLICE_W];

    CLA_16bit u_cla (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Sequencer: accept, run four slice passes, hold until retired.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_sub ? ~in_b : in_b;
                        carry <= in_sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[idx*SLICE_W +: SLICE_W] <= s_sum;
                    carry <= s_cout;
                    idx   <= idx + 2'd1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ADD64_FLAGS_EN
    logic [3:0] flags;
    logic       res_zero;
    logic       ovf;

    assign res_zero = (result[HI-1:0] == '0)
                    && (s_sum == '0);
    assign ovf = (a_q[WIDTH-1] == b_q[WIDTH-1])
              && (s_sum[SLICE_W-1] != a_q[WIDTH-1]);

    // Flags are captured on the final slice pass.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags <= '0;
        end else if (state == RUN && last) begin
            flags[FLAG_N] <= s_sum[SLICE_W-1];
            flags[FLAG_Z] <= res_zero;
            flags[FLAG_C] <= s_cout;
            flags[FLAG_V] <= ovf;
        end
    end

    assign out_flags = flags;
`else
    assign out_flags = 4'b0000;
`endif

endmodule
